// File: rtl/accum_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_cpu_pkg
// Description : Shared definitions for the accumulator CPU core: opcode
//               values, SKIP condition codes, FSM state encoding and ALU
//               operation selects.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_cpu_pkg;

    // Opcodes live in the top four bits of the instruction word
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_BACK  = 4'h8;
    localparam logic [3:0] OP_SKIP  = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_CLEAR = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hE;
    localparam logic [3:0] OP_NOT   = 4'hF;

    // SKIP condition field (two bits directly below the opcode)
    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_IR_LD  = 4'd2,
        ST_DECODE = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_MBR_LD = 4'd5,
        ST_EXEC   = 4'd6,
        ST_STORE  = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_NOT_B  = 3'd5
    } alu_op_e;

    // Memory-operand opcodes map onto one ALU operation each
    function automatic alu_op_e alu_sel_for(input logic [3:0] opcode);
        alu_op_e sel;
        sel = ALU_PASS_B;
        case (opcode)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_NOT:  sel = ALU_NOT_B;
            default: sel = ALU_PASS_B;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_cpu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_cpu_core_if
// Description : Single-port synchronous RAM bus between the CPU core (master)
//               and the memory (slave).
//               cs/we/oe/addr/wdata : master -> slave
//               rdata               : slave -> master, valid one cycle after
//                                     a read request
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_cpu_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output cs, we, oe, addr, wdata, input  rdata);
    modport slave  (input  cs, we, oe, addr, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
// ============================================================================
// Module      : accum_alu
// Description : Combinational ALU for the accumulator core.
//               i_a   : accumulator value
//               i_b   : memory operand (MBR)
//               i_sel : operation select
//               o_y   : result, modulo 2^DATA_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module accum_alu
    import accum_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  alu_op_e               i_sel,
    output logic [DATA_WIDTH-1:0] o_y
);
    always_comb begin
        o_y = i_b;
        case (i_sel)
            ALU_ADD:   o_y = i_a + i_b;
            ALU_SUB:   o_y = i_a - i_b;
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_NOT_B: o_y = ~i_b;
            default:   o_y = i_b;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/accum_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : accum_cpu_core
// Description : Multi-cycle accumulator CPU (PC/IR/MBR/AC) fetching from an
//               external synchronous single-port RAM.
//               clk, rst_n     : clock, asynchronous active-low reset
//               start          : begin/resume pulse (ignored while busy)
//               busy, halted   : run status
//               mem            : RAM bus (master side)
//               pc_o, ac_o     : architectural state
//               instr_count    : retired instructions since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module accum_cpu_core
    import accum_cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  halted,
    accum_cpu_core_if.master      mem,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ac_o,
    output logic [CNT_WIDTH-1:0]  instr_count
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [3:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic                  w_skip_take;
    logic                  w_ac_neg;
    logic                  w_ac_zero;
    logic [DATA_WIDTH-1:0] w_alu_y;
    logic                  w_retire;
    logic                  w_cs, w_we, w_oe;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_opcode = ir_q[DATA_WIDTH-1:DATA_WIDTH-4];

    // Operand field is zero-extended or truncated to the address width
    generate
        if (DATA_WIDTH - 4 >= ADDR_WIDTH) begin : g_opnd_trunc
            assign w_operand = ir_q[ADDR_WIDTH-1:0];
        end else begin : g_opnd_zext
            assign w_operand = {{(ADDR_WIDTH-DATA_WIDTH+4){1'b0}}, ir_q[DATA_WIDTH-5:0]};
        end
    endgenerate

    // SKIP treats AC as signed two's complement
    assign w_ac_neg  = ac_q[DATA_WIDTH-1];
    assign w_ac_zero = (ac_q == '0);

    always_comb begin
        w_skip_take = 1'b0;
        case (ir_q[DATA_WIDTH-5:DATA_WIDTH-6])
            SKIP_NEG:   w_skip_take = w_ac_neg;
            SKIP_ZERO:  w_skip_take = w_ac_zero;
            SKIP_POS:   w_skip_take = !w_ac_neg && !w_ac_zero;
            SKIP_NEVER: w_skip_take = 1'b0;
        endcase
    end

    accum_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_a   (ac_q),
        .i_b   (mbr_q),
        .i_sel (alu_sel_for(w_opcode)),
        .o_y   (w_alu_y)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mbr_d    = mbr_q;
        ac_d     = ac_q;
        cnt_d    = cnt_q;
        w_retire = 1'b0;
        w_cs     = 1'b0;
        w_we     = 1'b0;
        w_oe     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                w_cs    = 1'b1;
                w_oe    = 1'b1;
                w_addr  = pc_q;
                state_d = ST_IR_LD;
            end
            ST_IR_LD: begin
                ir_d    = mem.rdata;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                case (w_opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: state_d = ST_MEM_RD;
                    OP_STORE: state_d = ST_STORE;
                    OP_BACK: begin
                        pc_d     = pc_q - w_operand;
                        w_retire = 1'b1;
                    end
                    OP_SKIP: begin
                        if (w_skip_take) pc_d = pc_q + ADDR_WIDTH'(1);
                        w_retire = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_d     = w_operand;
                        w_retire = 1'b1;
                    end
                    OP_CLEAR: begin
                        ac_d     = '0;
                        w_retire = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = ST_HALT;
                        w_retire = 1'b1;
                    end
                    default: w_retire = 1'b1;
                endcase
            end
            ST_MEM_RD: begin
                w_cs    = 1'b1;
                w_oe    = 1'b1;
                w_addr  = w_operand;
                state_d = ST_MBR_LD;
            end
            ST_MBR_LD: begin
                mbr_d   = mem.rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ac_d     = w_alu_y;
                w_retire = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_STORE: begin
                w_cs     = 1'b1;
                w_we     = 1'b1;
                w_addr   = w_operand;
                w_wdata  = ac_q;
                w_retire = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_retire) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Bus strobes decode from state, so an async reset drops them at once
    // and a write in flight can never complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mbr_q   <= '0;
            ac_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mbr_q   <= mbr_d;
            ac_q    <= ac_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem.cs      = w_cs;
    assign mem.we      = w_we;
    assign mem.oe      = w_oe;
    assign mem.addr    = w_addr;
    assign mem.wdata   = w_wdata;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign pc_o        = pc_q;
    assign ac_o        = ac_q;
    assign instr_count = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_accum_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_cpu_core
// Description : Testbench for accum_cpu_core. An instruction-level reference
//               model predicts memory writes and the halt state; a monitor
//               compares them against the bus and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_cpu_core;
    localparam int DW = 16;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, halted;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] ac_o;
    logic [15:0]   instr_count;

    accum_cpu_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    accum_cpu_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('h100), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .halted      (halted),
        .mem         (bus.master),
        .pc_o        (pc_o),
        .ac_o        (ac_o),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    bit sb_en    = 1'b1;
    bit prev_h   = 1'b0;

    // Synchronous single-port RAM
    logic [15:0] mem [0:32767];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cs && bus.we) mem[bus.addr] = bus.wdata;
        if (bus.cs && bus.oe) bus.rdata <= mem[bus.addr];
    end

    // Reference model state
    logic [15:0] m_mem [0:32767];
    logic [14:0] m_pc;
    logic [15:0] m_ac;
    logic [15:0] m_cnt;

    typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [14:0] pc; logic [15:0] ac; logic [15:0] cnt; int cycles; } halt_t;
    wr_t   exp_wr[$];
    halt_t exp_halt[$];
    wr_t   tmp_wr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic ld(input logic [14:0] a, input logic [15:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    // Instruction-level interpreter: runs from the model PC until HALT
    task automatic model_run(output bit ok, output int cycles, output halt_t h);
        logic [15:0] ir;
        logic [14:0] opnd;
        logic signed [15:0] sac;
        bit take, done;
        ok = 1'b0; cycles = 0; done = 1'b0;
        h = '{pc: '0, ac: '0, cnt: '0, cycles: 0};
        tmp_wr.delete();
        for (int step = 0; step < 150 && !done; step++) begin
            ir    = m_mem[m_pc];
            m_pc  = m_pc + 15'd1;
            opnd  = {3'b000, ir[11:0]};
            m_cnt = m_cnt + 16'd1;
            cycles += 3;
            case (ir[15:12])
                4'h1: begin m_ac = m_mem[opnd];          cycles += 3; end
                4'h2: begin m_mem[opnd] = m_ac; tmp_wr.push_back('{addr: opnd, data: m_ac}); cycles += 1; end
                4'h3: begin m_ac = m_ac + m_mem[opnd];   cycles += 3; end
                4'h4: begin m_ac = m_ac - m_mem[opnd];   cycles += 3; end
                4'h5: begin m_ac = m_ac & m_mem[opnd];   cycles += 3; end
                4'h6: begin m_ac = m_ac | m_mem[opnd];   cycles += 3; end
                4'hF: begin m_ac = ~m_mem[opnd];         cycles += 3; end
                4'h8: m_pc = m_pc - opnd;
                4'h9: begin
                    sac = m_ac;
                    case (ir[11:10])
                        2'b00:   take = (sac < 0);
                        2'b01:   take = (sac == 0);
                        2'b10:   take = (sac > 0);
                        default: take = 1'b0;
                    endcase
                    if (take) m_pc = m_pc + 15'd1;
                end
                4'hA: m_pc = opnd;
                4'hB: m_ac = '0;
                4'hE: begin
                    done = 1'b1;
                    ok   = 1'b1;
                    h    = '{pc: m_pc, ac: m_ac, cnt: m_cnt, cycles: cycles};
                end
                default: ;
            endcase
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or halts
    always @(negedge clk) begin
        wr_t   ew;
        halt_t eh;
        if (rst_n) begin
            if (bus.cs) check("we_oe_exclusive", {31'd0, bus.we && bus.oe}, 32'd0);
            if (sb_en && bus.cs && bus.we) begin
                if (exp_wr.size() == 0) check("unexpected_write_addr", {17'd0, bus.addr}, 32'hFFFF_FFFF);
                else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", {17'd0, bus.addr}, {17'd0, ew.addr});
                    check("wr_data", {16'd0, bus.wdata}, {16'd0, ew.data});
                end
            end
            if (sb_en && halted && !prev_h) begin
                if (exp_halt.size() == 0) check("unexpected_halt_pc", {17'd0, pc_o}, 32'hFFFF_FFFF);
                else begin
                    eh = exp_halt.pop_front();
                    check("halt_pc",     {17'd0, pc_o},        {17'd0, eh.pc});
                    check("halt_ac",     {16'd0, ac_o},        {16'd0, eh.ac});
                    check("halt_cnt",    {16'd0, instr_count}, {16'd0, eh.cnt});
                    check("halt_cycles", cyc - start_cyc,      eh.cycles + 1);
                    check("halt_busy",   {31'd0, busy},        32'd0);
                end
            end
        end
        prev_h = halted;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        m_pc = 15'h100; m_ac = '0; m_cnt = '0;
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int max_cyc);
        int i;
        i = 0;
        while (!halted && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        @(negedge clk);
    endtask

    // Runs the model, queues its predictions, then runs the DUT
    task automatic run_prog(input bit poke);
        bit    ok;
        int    mc;
        halt_t h;
        model_run(ok, mc, h);
        foreach (tmp_wr[i]) exp_wr.push_back(tmp_wr[i]);
        if (ok) exp_halt.push_back(h);
        pulse_start();
        check("start_clears_halted", {31'd0, halted}, 32'd0);
        check("start_sets_busy",     {31'd0, busy},   32'd1);
        if (poke) begin
            repeat (5) @(negedge clk);
            if (busy) start = 1'b1;   // must be ignored
            @(negedge clk);
            start = 1'b0;
        end
        wait_halt(mc + 20);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, attempts;
        bit ok;
        int mc;
        halt_t h;
        logic [3:0]  op;
        logic [11:0] opnd;

        for (int i = 0; i < 32768; i++) begin mem[i] = '0; m_mem[i] = '0; end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc",     {17'd0, pc_o},        32'h100);
        check("rst_ac",     {16'd0, ac_o},        32'd0);
        check("rst_cnt",    {16'd0, instr_count}, 32'd0);
        check("rst_busy",   {31'd0, busy},        32'd0);
        check("rst_halted", {31'd0, halted},      32'd0);
        check("rst_mem",    {29'd0, bus.cs, bus.we, bus.oe}, 32'd0);
        m_pc = 15'h100; m_ac = '0; m_cnt = '0;
        rst_n = 1'b1;

        // LOAD/ADD/STORE/HALT example
        ld(15'h10C, 16'h0007); ld(15'h10B, 16'h0005);
        ld(15'h100, 16'h110C); ld(15'h101, 16'h310B); ld(15'h102, 16'h210D); ld(15'h103, 16'hE000);
        run_prog(1'b0);
        check("ex_m10d",   {16'd0, mem[15'h10D]},  32'h000C);
        check("ex_cnt",    {16'd0, instr_count},   32'd4);
        check("ex_pc",     {17'd0, pc_o},          32'h104);
        check("ex_halted", {31'd0, halted},        32'd1);

        // Resume after HALT: SUB/NOT/AND/OR wrap, JUMP, BACK 0, BACK 2
        ld(15'h201, 16'h0001); ld(15'h202, 16'h00FF); ld(15'h203, 16'hF0F0); ld(15'h204, 16'h0FF0);
        ld(15'h104, 16'hA130);
        ld(15'h130, 16'hB000); ld(15'h131, 16'h4201); ld(15'h132, 16'h2210);
        ld(15'h133, 16'hF202); ld(15'h134, 16'h2211);
        ld(15'h135, 16'h1203); ld(15'h136, 16'h5204); ld(15'h137, 16'h2212);
        ld(15'h138, 16'h1203); ld(15'h139, 16'h6204); ld(15'h13A, 16'h2213);
        ld(15'h13B, 16'hA140);
        ld(15'h140, 16'h8000); ld(15'h141, 16'hA143); ld(15'h142, 16'hE000); ld(15'h143, 16'h8002);
        run_prog(1'b1);
        check("sub_wrap", {16'd0, mem[15'h210]}, 32'hFFFF);
        check("not_m",    {16'd0, mem[15'h211]}, 32'hFF00);
        check("and_m",    {16'd0, mem[15'h212]}, 32'h00F0);
        check("or_m",     {16'd0, mem[15'h213]}, 32'hFFF0);
        check("res_pc",   {17'd0, pc_o},         32'h143);
        check("res_cnt",  {16'd0, instr_count},  32'd21);

        // Signed SKIP
        do_reset();
        ld(15'h200, 16'hFFFF); ld(15'h201, 16'h0001); ld(15'h202, 16'h8000);
        ld(15'h100, 16'h1200); ld(15'h101, 16'h9000); ld(15'h102, 16'h1201); ld(15'h103, 16'h2210);
        ld(15'h104, 16'hB000); ld(15'h105, 16'h9400); ld(15'h106, 16'h1201); ld(15'h107, 16'h2211);
        ld(15'h108, 16'h1202); ld(15'h109, 16'h9800); ld(15'h10A, 16'h3201); ld(15'h10B, 16'h2212);
        ld(15'h10C, 16'hA110); ld(15'h110, 16'h9C00); ld(15'h111, 16'hE000);
        run_prog(1'b1);
        check("skip_neg",   {16'd0, mem[15'h210]}, 32'hFFFF);
        check("skip_zero",  {16'd0, mem[15'h211]}, 32'h0000);
        check("noskip_pos", {16'd0, mem[15'h212]}, 32'h8001);
        check("skip_pc",    {17'd0, pc_o},         32'h112);

        // PC wrap at 0x7FFF
        do_reset();
        ld(15'h200, 16'h0055);
        ld(15'h100, 16'h1200); ld(15'h101, 16'h8103); ld(15'h7FFF, 16'h2210); ld(15'h0000, 16'hE000);
        run_prog(1'b0);
        check("wrap_store", {16'd0, mem[15'h210]}, 32'h0055);
        check("wrap_pc",    {17'd0, pc_o},         32'h0001);

        // Reset in the middle of a STORE
        do_reset();
        sb_en = 1'b0;
        ld(15'h200, 16'h1234); ld(15'h201, 16'hAAAA);
        ld(15'h100, 16'h1200); ld(15'h101, 16'h2201); ld(15'h102, 16'hE000);
        pulse_start();
        for (int i = 0; i < 30 && !(bus.cs && bus.we); i++) @(negedge clk);
        check("mid_store_seen", {31'd0, bus.we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {30'd0, bus.we, bus.cs}, 32'd0);
        check("mid_rst_pc", {17'd0, pc_o},           32'h100);
        check("mid_rst_ac", {16'd0, ac_o},           32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("mid_rst_mem", {16'd0, mem[15'h201]},  32'hAAAA);
        sb_en = 1'b1;

        // Random programs
        done_cnt = 0; attempts = 0;
        while (done_cnt < 20 && attempts < 300) begin
            attempts++;
            do_reset();
            for (int a = 'h200; a < 'h220; a++) begin
                case ($urandom_range(0, 5))
                    0:       ld(15'(a), 16'h0000);
                    1:       ld(15'(a), 16'h8000);
                    2:       ld(15'(a), 16'hFFFF);
                    default: ld(15'(a), 16'($urandom));
                endcase
            end
            for (int a = 'h100; a < 'h120; a++) begin
                op = 4'($urandom_range(0, 15));
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF: opnd = 12'h200 + 12'($urandom_range(0, 31));
                    4'h8:    opnd = 12'($urandom_range(0, 3));
                    4'hA:    opnd = 12'h100 + 12'($urandom_range(0, 31));
                    default: opnd = 12'($urandom);
                endcase
                ld(15'(a), {op, opnd});
            end
            for (int a = 'h120; a < 'h128; a++) ld(15'(a), 16'hE000);
            model_run(ok, mc, h);
            m_pc = 15'h100; m_ac = '0; m_cnt = '0;
            for (int a = 'h200; a < 'h220; a++) m_mem[a] = mem[a];
            if (ok) begin
                run_prog(done_cnt[0]);
                done_cnt++;
            end
        end

        check("wr_queue_drained",   exp_wr.size(),   32'd0);
        check("halt_queue_drained", exp_halt.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
